// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR indices, bit positions and AXI-Lite FSM state types
package csr_pkg;

    localparam int CTRL_IDX   = 0;
    localparam int STATUS_IDX = 1;

    localparam int START_BIT = 0;
    localparam int DONE_BIT  = 0;
    localparam int BUSY_BIT  = 1;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_HALF = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_e;

endpackage

// File: rtl/csr_reg_bank.sv
// rtl/csr_reg_bank.sv - CSR array with byte-strobe writes, flat read mux and start/busy/done logic
module csr_reg_bank
    import csr_pkg::*;
#(
    parameter int CSR_REG_NUM      = 64,
    parameter int LOG2_CSR_REG_NUM = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en_i,
    input  logic [LOG2_CSR_REG_NUM-1:0]   wr_idx_i,
    input  logic [31:0]                   wr_data_i,
    input  logic [3:0]                    wr_strb_i,
    input  logic [LOG2_CSR_REG_NUM-1:0]   rd_idx_i,
    output logic [31:0]                   rd_data_o,
    output logic [32*CSR_REG_NUM-1:0]     reg_flat_o,
    input  logic                          done_i,
    output logic                          start_o
);

    // CTRL and STATUS have no array storage; only config registers live here.
    logic [31:0] regs_q [2:CSR_REG_NUM-1];
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        start_q, start_d;
    logic        ctrl_go;
    logic        status_w1c;
    logic [31:0] status_word;

    assign ctrl_go    = wr_en_i && (wr_idx_i == LOG2_CSR_REG_NUM'(CTRL_IDX))
                        && wr_strb_i[0] && wr_data_i[START_BIT];
    assign status_w1c = wr_en_i && (wr_idx_i == LOG2_CSR_REG_NUM'(STATUS_IDX))
                        && wr_strb_i[0] && wr_data_i[DONE_BIT];

    // Later assignments win: a done pulse overrides a same-edge W1C clear.
    always_comb begin
        start_d = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;
        if (status_w1c) begin
            done_d = 1'b0;
        end
        if (ctrl_go && !busy_q) begin
            start_d = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end
        if (done_i) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= start_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 2; i < CSR_REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            for (int i = 2; i < CSR_REG_NUM; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_idx_i == LOG2_CSR_REG_NUM'(i) && wr_strb_i[b]) begin
                        regs_q[i][8*b +: 8] <= wr_data_i[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        status_word           = '0;
        status_word[BUSY_BIT] = busy_q;
        status_word[DONE_BIT] = done_q;
    end

    always_comb begin
        reg_flat_o                        = '0;
        reg_flat_o[32*STATUS_IDX +: 32]   = status_word;
        for (int i = 2; i < CSR_REG_NUM; i++) begin
            reg_flat_o[32*i +: 32] = regs_q[i];
        end
    end

    assign rd_data_o = reg_flat_o[{rd_idx_i, 5'd0} +: 32];
    assign start_o   = start_q;

endmodule

// File: rtl/csr_axi_lite_slave.sv
// rtl/csr_axi_lite_slave.sv - AXI4-Lite responder with independent AW/W capture and single-beat read path
module csr_axi_lite_slave
    import csr_pkg::*;
#(
    parameter int CSR_REG_NUM      = 64,
    parameter int LOG2_CSR_REG_NUM = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [LOG2_CSR_REG_NUM+1:0]   S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    input  logic [LOG2_CSR_REG_NUM+1:0]   S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [32*CSR_REG_NUM-1:0]     csr_reg_flat,
    output logic                          start,
    input  logic                          done
);

    wr_state_e                     wr_state_q, wr_state_d;
    rd_state_e                     rd_state_q, rd_state_d;
    logic                          ready_en_q;
    logic                          aw_held_q, aw_held_d;
    logic                          w_held_q, w_held_d;
    logic [LOG2_CSR_REG_NUM-1:0]   aw_idx_q;
    logic [31:0]                   wdata_q;
    logic [3:0]                    wstrb_q;
    logic [31:0]                   rdata_q;
    logic                          aw_hs, w_hs, ar_hs, commit;
    logic [LOG2_CSR_REG_NUM-1:0]   wr_idx;
    logic [31:0]                   wr_data, rd_data;
    logic [3:0]                    wr_strb;
    logic                          unused_bits;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_BVALID  = (wr_state_q == W_RESP);
    assign S_AXI_RVALID  = (rd_state_q == R_RESP);
    assign S_AXI_AWREADY = ready_en_q && !aw_held_q && !S_AXI_BVALID;
    assign S_AXI_WREADY  = ready_en_q && !w_held_q && !S_AXI_BVALID;
    assign S_AXI_ARREADY = ready_en_q && !S_AXI_RVALID;
    assign S_AXI_BRESP   = AXI_RESP_OKAY;
    assign S_AXI_RRESP   = AXI_RESP_OKAY;
    assign S_AXI_RDATA   = rdata_q;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit = (wr_state_q != W_RESP) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

    // Whichever half arrives on the completing edge bypasses its holding register.
    assign wr_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[LOG2_CSR_REG_NUM+1:2];
    assign wr_data = w_held_q ? wdata_q : S_AXI_WDATA;
    assign wr_strb = w_held_q ? wstrb_q : S_AXI_WSTRB;

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        unique case (wr_state_q)
            W_IDLE, W_HALF: begin
                if (commit) begin
                    wr_state_d = W_RESP;
                    aw_held_d  = 1'b1;
                    w_held_d   = 1'b1;
                end else if (aw_hs || w_hs) begin
                    wr_state_d = W_HALF;
                    aw_held_d  = aw_held_q || aw_hs;
                    w_held_d   = w_held_q || w_hs;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    wr_state_d = W_IDLE;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
                aw_held_d  = 1'b0;
                w_held_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        if (rd_state_q == R_IDLE) begin
            if (ar_hs) rd_state_d = R_RESP;
        end else if (S_AXI_RREADY) begin
            rd_state_d = R_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            ready_en_q <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            ready_en_q <= 1'b1;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            if (aw_hs) aw_idx_q <= S_AXI_AWADDR[LOG2_CSR_REG_NUM+1:2];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (ar_hs) rdata_q <= rd_data;
        end
    end

    csr_reg_bank #(
        .CSR_REG_NUM      (CSR_REG_NUM),
        .LOG2_CSR_REG_NUM (LOG2_CSR_REG_NUM)
    ) u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (commit),
        .wr_idx_i   (wr_idx),
        .wr_data_i  (wr_data),
        .wr_strb_i  (wr_strb),
        .rd_idx_i   (S_AXI_ARADDR[LOG2_CSR_REG_NUM+1:2]),
        .rd_data_o  (rd_data),
        .reg_flat_o (csr_reg_flat),
        .done_i     (done),
        .start_o    (start)
    );

endmodule
